// File: rtl/comb_sweep_checker_pkg.sv
// Shared types and constants for the combinational sweep checker.
// Both the top level and the settle timer import this package.
package comb_sweep_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } sweep_state_t;

  localparam int         NUM_PAT  = 16;
  localparam logic [3:0] LAST_PAT = 4'd15;

  // A pattern is held for SETTLE cycles, so the counter restarts one below that.
  function automatic logic [3:0] settle_reload(input int settle);
    return 4'(settle - 1);
  endfunction

endpackage

// File: rtl/comb_sweep_checker_if.sv
// Stimulus/response and result bundle between the sweep checker and its surroundings.
// The master side is the checker itself; the slave side is the block under test and its observer.
interface comb_sweep_checker_if;
  import comb_sweep_checker_pkg::*;

  logic               start;
  logic               y_in;
  logic [3:0]         abcd_out;
  logic               busy;
  logic               done;
  logic               pass;
  logic [4:0]         err_cnt;
  logic [3:0]         first_fail;
  logic               first_fail_vld;
  logic [NUM_PAT-1:0] resp_map;

  modport master (
    input  start, y_in,
    output abcd_out, busy, done, pass, err_cnt, first_fail, first_fail_vld, resp_map
  );

  modport slave (
    output start, y_in,
    input  abcd_out, busy, done, pass, err_cnt, first_fail, first_fail_vld, resp_map
  );

endinterface

// File: rtl/comb_sweep_checker_settle_timer.sv
// Loadable 4-bit down-counter that times how long each pattern is held.
// zero marks the cycle on which the response may be sampled.
module sweep_settle_timer
  import comb_sweep_checker_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam logic [3:0] RELOAD = settle_reload(SETTLE);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= RELOAD;
    end else if (dec && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/comb_sweep_checker.sv
// Built-in self-test sweeper: walks a 4-input combinational block through all 16
// patterns, samples Y after a settle time and scores it against an expected truth table.
module comb_sweep_checker
  import comb_sweep_checker_pkg::*;
#(
  parameter int          SETTLE = 2,
  parameter logic [15:0] EXPECT = 16'h0000
) (
  input logic clk,
  input logic rst_n,
  comb_sweep_checker_if.master bus
);

  sweep_state_t state, state_nxt;

  logic       tmr_zero;
  logic       accept;
  logic       sample;
  logic       last_pat;
  logic       miss;
  logic [4:0] err_inc;

  assign accept   = (state == IDLE || state == DONE) && bus.start;
  assign sample   = (state == APPLY) && tmr_zero;
  assign last_pat = (bus.abcd_out == LAST_PAT);
  assign miss     = (bus.y_in != EXPECT[bus.abcd_out]);
  assign err_inc  = bus.err_cnt + {4'd0, miss};

  sweep_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept || (sample && !last_pat)),
    .dec   ((state == APPLY) && !tmr_zero),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start)           state_nxt = APPLY;
      APPLY:      if (sample && last_pat)  state_nxt = DONE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // Results are captured on the sample cycle; pass uses err_inc so pattern 15 counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.abcd_out       <= 4'd0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.pass           <= 1'b0;
      bus.err_cnt        <= 5'd0;
      bus.first_fail     <= 4'd0;
      bus.first_fail_vld <= 1'b0;
      bus.resp_map       <= '0;
    end else if (accept) begin
      bus.abcd_out       <= 4'd0;
      bus.busy           <= 1'b1;
      bus.done           <= 1'b0;
      bus.pass           <= 1'b0;
      bus.err_cnt        <= 5'd0;
      bus.first_fail     <= 4'd0;
      bus.first_fail_vld <= 1'b0;
      bus.resp_map       <= '0;
    end else if (sample) begin
      bus.resp_map[bus.abcd_out] <= bus.y_in;
      if (miss) begin
        bus.err_cnt <= err_inc;
        if (!bus.first_fail_vld) begin
          bus.first_fail     <= bus.abcd_out;
          bus.first_fail_vld <= 1'b1;
        end
      end
      if (last_pat) begin
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
        bus.pass <= (err_inc == 5'd0);
      end else begin
        bus.abcd_out <= bus.abcd_out + 4'd1;
      end
    end
  end

endmodule
